// File: rtl/mmu_walk_arbiter_if.sv
// Wishbone classic read-only bus between the walk arbiter (master) and the system bus (slave).
interface mmu_walk_arbiter_if;
  logic        cyc;
  logic        stb;
  logic [29:0] addr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] din;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, addr, sel, we, input din, ack, err);
  modport slave  (input cyc, stb, addr, sel, we, output din, ack, err);
endinterface

// File: rtl/mmu_walk_arbiter.sv
// Round-robin arbiter placing the I-side and D-side page walkers onto one Wishbone read master;
// bus errors and timeouts come back as a zero (not-present) entry plus a fault pulse.
//
// state  | meaning
// S_IDLE | no bus cycle; sample both ren inputs and pick a winner
// S_BUS  | wb_cyc/wb_stb high; waiting for err, ack or timeout
// S_RESP | pX_ack/fault pulse cycle; requesters are not sampled here
module mmu_walk_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int TO_BITS = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p0_ren,
  input  logic [31:0]         p0_addr,
  output logic                p0_ack,
  output logic [31:0]         p0_data,
  input  logic                p1_ren,
  input  logic [31:0]         p1_addr,
  output logic                p1_ack,
  output logic [31:0]         p1_data,
  mmu_walk_arbiter_if.master  wb,
  output logic                fault,
  output logic [31:0]         fault_addr
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [TO_BITS-1:0] CNT_LAST = TO_BITS'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic               grant, grant_nxt;
  logic               last_grant, last_grant_nxt;
  logic               abandon, abandon_nxt;
  logic               cyc, cyc_nxt;
  logic [TO_BITS-1:0] cnt, cnt_nxt;
  logic [29:0]        addr_q, addr_nxt;
  logic               p0_ack_nxt, p1_ack_nxt, fault_nxt;
  logic [31:0]        p0_data_nxt, p1_data_nxt, fault_addr_nxt;

  logic               pick, grant_ren, done, bad;
  logic [31:0]        rdata;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^{p0_addr[1:0], p1_addr[1:0]};

  always_comb begin
    pick      = (p0_ren && p1_ren) ? ~last_grant : p1_ren;
    grant_ren = grant ? p1_ren : p0_ren;
    done      = wb.err || wb.ack || (cnt == CNT_LAST);
    // err outranks a simultaneous ack, and a timeout has neither
    bad       = wb.err || !wb.ack;
    rdata     = bad ? 32'h0 : wb.din;
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    abandon_nxt    = abandon;
    cyc_nxt        = cyc;
    cnt_nxt        = cnt;
    addr_nxt       = addr_q;
    p0_ack_nxt     = 1'b0;
    p1_ack_nxt     = 1'b0;
    p0_data_nxt    = 32'h0;
    p1_data_nxt    = 32'h0;
    fault_nxt      = 1'b0;
    fault_addr_nxt = fault_addr;

    case (state)
      S_IDLE: begin
        if (p0_ren || p1_ren) begin
          grant_nxt      = pick;
          last_grant_nxt = pick;
          addr_nxt       = pick ? p1_addr[31:2] : p0_addr[31:2];
          cyc_nxt        = 1'b1;
          abandon_nxt    = 1'b0;
          cnt_nxt        = '0;
          state_nxt      = S_BUS;
        end
      end
      S_BUS: begin
        cnt_nxt = cnt + TO_BITS'(1);
        // a walker that lets go keeps the bus cycle alive but forfeits the response
        if (!grant_ren) abandon_nxt = 1'b1;
        if (done) begin
          cyc_nxt   = 1'b0;
          state_nxt = S_RESP;
          fault_nxt = bad;
          if (bad) fault_addr_nxt = {addr_q, 2'b00};
          if (!abandon && grant_ren) begin
            if (grant) begin
              p1_ack_nxt  = 1'b1;
              p1_data_nxt = rdata;
            end else begin
              p0_ack_nxt  = 1'b1;
              p0_data_nxt = rdata;
            end
          end
        end
      end
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      abandon    <= 1'b0;
      cyc        <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_data    <= 32'h0;
      p1_data    <= 32'h0;
      fault      <= 1'b0;
      fault_addr <= 32'h0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      abandon    <= abandon_nxt;
      cyc        <= cyc_nxt;
      cnt        <= cnt_nxt;
      addr_q     <= addr_nxt;
      p0_ack     <= p0_ack_nxt;
      p1_ack     <= p1_ack_nxt;
      p0_data    <= p0_data_nxt;
      p1_data    <= p1_data_nxt;
      fault      <= fault_nxt;
      fault_addr <= fault_addr_nxt;
    end
  end

  assign wb.cyc  = cyc;
  assign wb.stb  = cyc;
  assign wb.sel  = {4{cyc}};
  assign wb.we   = 1'b0;
  assign wb.addr = addr_q;

endmodule

// File: tb/tb_mmu_walk_arbiter.sv
// Directed bench for mmu_walk_arbiter: single-transaction vector table plus multi-cycle sequences.
module tb_mmu_walk_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_ren, p1_ren;
  logic [31:0] p0_addr, p1_addr;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_data, p1_data;
  logic        fault;
  logic [31:0] fault_addr;

  mmu_walk_arbiter_if wb ();

  mmu_walk_arbiter #(.TIMEOUT(256), .TO_BITS(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .p0_ren     (p0_ren),
    .p0_addr    (p0_addr),
    .p0_ack     (p0_ack),
    .p0_data    (p0_data),
    .p1_ren     (p1_ren),
    .p1_addr    (p1_addr),
    .p1_ack     (p1_ack),
    .p1_data    (p1_data),
    .wb         (wb.master),
    .fault      (fault),
    .fault_addr (fault_addr)
  );

  int checks = 0;
  int failures = 0;

  // slave model: responds in the (slv_lat+1)-th cycle of a bus cycle; slv_lat < 0 never responds
  int          slv_lat;
  logic        slv_ack, slv_err;
  logic [31:0] slv_din;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int wcnt;
    wcnt   = 0;
    wb.ack = 1'b0;
    wb.err = 1'b0;
    wb.din = 32'h0;
    forever begin
      @(negedge clk);
      if (wb.cyc) begin
        if (wcnt == slv_lat) begin
          wb.ack = slv_ack;
          wb.err = slv_err;
          wb.din = slv_din;
        end else begin
          wb.ack = 1'b0;
          wb.err = 1'b0;
        end
        wcnt++;
      end else begin
        wb.ack = 1'b0;
        wb.err = 1'b0;
        wcnt   = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic [31:0] addr;
    int          lat;
    logic        err;
    logic        ack;
    logic [31:0] din;
    logic [29:0] exp_wa;
    logic [31:0] exp_data;
    logic        exp_fault;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int ack_c;
    slv_lat = v.lat;
    slv_ack = v.ack;
    slv_err = v.err;
    slv_din = v.din;
    @(negedge clk);
    if (v.port) begin p1_ren = 1'b1; p1_addr = v.addr; end
    else        begin p0_ren = 1'b1; p0_addr = v.addr; end
    ack_c = -1;
    for (int c = 1; c <= 40 && ack_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("vec_cyc_rise", {31'h0, wb.cyc}, 32'h1);
        chk("vec_wb_addr", {2'b00, wb.addr}, {2'b00, v.exp_wa});
        chk("vec_wb_sel", {28'h0, wb.sel}, 32'hF);
      end
      if (p0_ack || p1_ack) begin
        ack_c = c;
        chk("vec_ack_port", {30'h0, p1_ack, p0_ack}, v.port ? 32'h2 : 32'h1);
        chk("vec_data", v.port ? p1_data : p0_data, v.exp_data);
        chk("vec_fault", {31'h0, fault}, {31'h0, v.exp_fault});
      end
    end
    chk("vec_ack_cycle", ack_c, v.exp_cyc);
    p0_ren = 1'b0;
    p1_ren = 1'b0;
    @(negedge clk);
    chk("vec_ack_clear", {30'h0, p1_ack, p0_ack}, 32'h0);
    chk("vec_data_clear", p0_data | p1_data, 32'h0);
    chk("vec_fault_clear", {31'h0, fault}, 32'h0);
    if (v.exp_fault) chk("vec_fault_addr", fault_addr, {v.exp_wa, 2'b00});
  endtask

  task automatic wait_ack(input int bound, output int cyc_n);
    cyc_n = -1;
    for (int c = 1; c <= bound && cyc_n < 0; c++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) cyc_n = c;
    end
  endtask

  initial begin
    int ack_c, cyc_cnt, fault_cnt, ack_cnt, starts;
    logic prev_cyc;

    vecs[0] = '{1'b0, 32'h0010_0FFC, 0, 1'b0, 1'b1, 32'h1234_5001, 30'h0004_03FF, 32'h1234_5001, 1'b0, 2};
    vecs[1] = '{1'b1, 32'h8000_0003, 2, 1'b0, 1'b1, 32'hDEAD_BEEF, 30'h2000_0000, 32'hDEAD_BEEF, 1'b0, 4};
    vecs[2] = '{1'b0, 32'hFFFF_FFF8, 1, 1'b1, 1'b0, 32'h0000_5555, 30'h3FFF_FFFE, 32'h0000_0000, 1'b1, 3};
    vecs[3] = '{1'b1, 32'h0000_1004, 0, 1'b1, 1'b1, 32'hAAAA_AAAA, 30'h0000_0401, 32'h0000_0000, 1'b1, 2};
    vecs[4] = '{1'b1, 32'h0ABC_DEF0, 5, 1'b0, 1'b1, 32'hCAFE_F00D, 30'h02AF_37BC, 32'hCAFE_F00D, 1'b0, 7};

    rst = 1'b1;
    p0_ren = 1'b0; p1_ren = 1'b0;
    p0_addr = 32'h0; p1_addr = 32'h0;
    slv_lat = 0; slv_ack = 1'b1; slv_err = 1'b0; slv_din = 32'hA5A5_0001;
    repeat (3) @(negedge clk);

    chk("rst_cyc_stb", {30'h0, wb.cyc, wb.stb}, 32'h0);
    chk("rst_sel_we", {27'h0, wb.sel, wb.we}, 32'h0);
    chk("rst_wb_addr", {2'b00, wb.addr}, 32'h0);
    chk("rst_acks", {30'h0, p1_ack, p0_ack}, 32'h0);
    chk("rst_data", p0_data | p1_data, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_fault_addr", fault_addr, 32'h0);

    // simultaneous requests straight out of reset: p0, then p1, then p0 again
    rst = 1'b0;
    p0_ren = 1'b1; p0_addr = 32'h0000_1000;
    p1_ren = 1'b1; p1_addr = 32'h0000_2000;
    @(negedge clk);
    chk("tie_c1_addr_p0", {2'b00, wb.addr}, 32'h400);
    @(negedge clk);
    chk("tie_c2_acks", {30'h0, p1_ack, p0_ack}, 32'h1);
    chk("tie_c2_data", p0_data, 32'hA5A5_0001);
    p0_ren = 1'b0;
    @(negedge clk);
    chk("tie_c3_cyc_low", {31'h0, wb.cyc}, 32'h0);
    @(negedge clk);
    chk("tie_c4_cyc", {31'h0, wb.cyc}, 32'h1);
    chk("tie_c4_addr_p1", {2'b00, wb.addr}, 32'h800);
    @(negedge clk);
    chk("tie_c5_acks", {30'h0, p1_ack, p0_ack}, 32'h2);
    p1_ren = 1'b0;
    @(negedge clk);
    @(negedge clk);
    p0_ren = 1'b1; p0_addr = 32'h0000_3000;
    p1_ren = 1'b1; p1_addr = 32'h0000_4000;
    @(negedge clk);
    chk("tie3_addr_p0", {2'b00, wb.addr}, 32'hC00);
    wait_ack(10, ack_c);
    chk("tie3_ack_p0", {30'h0, p1_ack, p0_ack}, 32'h1);
    p0_ren = 1'b0; p1_ren = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // silent slave: forced abort after TIMEOUT bus cycles
    slv_lat = -1; slv_ack = 1'b1; slv_err = 1'b0;
    @(negedge clk);
    p0_ren = 1'b1; p0_addr = 32'h0000_0400;
    cyc_cnt = 0; fault_cnt = 0; ack_c = -1;
    for (int c = 1; c <= 300 && ack_c < 0; c++) begin
      @(negedge clk);
      cyc_cnt += int'(wb.cyc);
      fault_cnt += int'(fault);
      if (p0_ack || p1_ack) begin
        ack_c = c;
        chk("to_data", p0_data, 32'h0);
        chk("to_fault", {31'h0, fault}, 32'h1);
      end
    end
    chk("to_ack_cycle", ack_c, 257);
    chk("to_cyc_len", cyc_cnt, 256);
    p0_ren = 1'b0;
    @(negedge clk);
    fault_cnt += int'(fault);
    chk("to_fault_once", fault_cnt, 1);
    chk("to_fault_addr", fault_addr, 32'h0000_0400);

    // p1 abandons, re-requests with a new address before the slave answers
    slv_lat = 6; slv_ack = 1'b1; slv_err = 1'b0; slv_din = 32'h7777_0001;
    @(negedge clk);
    p1_ren = 1'b1; p1_addr = 32'h0000_8000;
    ack_cnt = 0; fault_cnt = 0; starts = 0; ack_c = -1; prev_cyc = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (wb.cyc && !prev_cyc) begin
        starts++;
        if (starts == 1) chk("ab_addr_old", {2'b00, wb.addr}, 32'h2000);
        if (starts == 2) begin
          chk("ab_addr_new", {2'b00, wb.addr}, 32'h2400);
          chk("ab_restart_cycle", c, 10);
        end
      end
      prev_cyc = wb.cyc;
      fault_cnt += int'(fault);
      if (p0_ack || p1_ack) begin
        ack_cnt++;
        ack_c = c;
        chk("ab_ack_data", p1_data, 32'h7777_0001);
        p1_ren = 1'b0;
      end
      if (c == 2) p1_ren = 1'b0;
      if (c == 4) begin p1_ren = 1'b1; p1_addr = 32'h0000_9000; end
    end
    chk("ab_ack_count", ack_cnt, 1);
    chk("ab_ack_cycle", ack_c, 17);
    chk("ab_no_fault", fault_cnt, 0);
    p1_ren = 1'b0;
    @(negedge clk);

    // reset in the middle of a p0 bus cycle; afterwards p0 must win the tie again
    slv_lat = -1;
    p0_ren = 1'b1; p0_addr = 32'h0000_5000;
    repeat (3) @(negedge clk);
    chk("rm_cyc_before", {31'h0, wb.cyc}, 32'h1);
    rst = 1'b1;
    p0_ren = 1'b0;
    @(negedge clk);
    chk("rm_cyc_dropped", {30'h0, wb.cyc, wb.stb}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ack_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ack_cnt += int'(p0_ack) + int'(p1_ack);
    end
    chk("rm_no_ack", ack_cnt, 0);
    slv_lat = 0; slv_din = 32'h0BAD_F00D;
    p0_ren = 1'b1; p0_addr = 32'h0000_6000;
    p1_ren = 1'b1; p1_addr = 32'h0000_7000;
    @(negedge clk);
    chk("rm_tie_addr_p0", {2'b00, wb.addr}, 32'h1800);
    wait_ack(10, ack_c);
    chk("rm_tie_ack_p0", {30'h0, p1_ack, p0_ack}, 32'h1);
    p0_ren = 1'b0; p1_ren = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
